// File: rtl/barrett_reduce_tail_if.sv
`default_nettype none
// ============================================================================
// Module      : barrett_reduce_tail_if
// Description : Request/response bundle for the Barrett reduction tail stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface barrett_reduce_tail_if #(
  parameter int RADIX = 54
);
  logic             in_valid;
  logic             in_ready;
  logic [RADIX-1:0] q;
  logic [RADIX+1:0] x_low;
  logic [RADIX-1:0] m;
  logic             out_valid;
  logic             out_ready;
  logic [RADIX-1:0] r;
  logic             corr_err;

  modport master (
    output in_valid, q, x_low, m, out_ready,
    input  in_ready, out_valid, r, corr_err
  );

  modport slave (
    input  in_valid, q, x_low, m, out_ready,
    output in_ready, out_valid, r, corr_err
  );
endinterface
`default_nettype wire

// File: rtl/barrett_reduce_tail.sv
`default_nettype none
// ============================================================================
// Module      : barrett_reduce_tail
// Description : r = (x_low - q*m) mod 2^(RADIX+2) with two conditional
//               subtractions of m; q*m built on one shared LIMB x LIMB multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module barrett_reduce_tail #(
  parameter int RADIX = 54,
  parameter int LIMB  = 18
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  barrett_reduce_tail_if.slave    bus
);
  localparam int NLIMB = RADIX / LIMB;
  localparam int W     = RADIX + 2;
  localparam int IW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  localparam logic [IW-1:0] c_last = IW'(NLIMB - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_SUB  = 3'd2,
    S_COR1 = 3'd3,
    S_COR2 = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t           r_state;
  logic [RADIX-1:0] r_q;
  logic [RADIX-1:0] r_m;
  logic [W-1:0]     r_x;
  logic [W-1:0]     r_acc;
  logic [W-1:0]     r_t;
  logic [IW-1:0]    r_i;
  logic [IW-1:0]    r_j;
  logic [RADIX-1:0] r_r;
  logic             r_corr;
  logic             r_out_valid;
  logic             r_in_ready;

  logic [LIMB-1:0]     w_q_limb;
  logic [LIMB-1:0]     w_m_limb;
  logic [2*LIMB-1:0]   w_prod;
  logic [W+2*LIMB-1:0] w_prod_ext;
  logic [31:0]         w_shamt;
  logic [W-1:0]        w_term;
  logic [W-1:0]        w_m_ext;
  logic [W-1:0]        w_t_cor;

  // The single shared multiplier: one limb pair per MUL cycle.
  assign w_q_limb   = r_q[32'(r_i)*LIMB +: LIMB];
  assign w_m_limb   = r_m[32'(r_j)*LIMB +: LIMB];
  assign w_prod     = w_q_limb * w_m_limb;
  assign w_prod_ext = {{W{1'b0}}, w_prod};
  assign w_shamt    = LIMB * (32'(r_i) + 32'(r_j));
  // Partial products landing above bit W-1 are discarded by the truncation.
  assign w_term     = W'(w_prod_ext << w_shamt);

  assign w_m_ext = {2'b00, r_m};
  assign w_t_cor = (r_t >= w_m_ext) ? (r_t - w_m_ext) : r_t;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_q         <= '0;
      r_m         <= '0;
      r_x         <= '0;
      r_acc       <= '0;
      r_t         <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_r         <= '0;
      r_corr      <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_q        <= bus.q;
            r_m        <= bus.m;
            r_x        <= bus.x_low;
            r_acc      <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_MUL;
          end
        end
        S_MUL: begin
          r_acc <= r_acc + w_term;
          if (r_j == c_last) begin
            r_j <= '0;
            if (r_i == c_last) begin
              r_i     <= '0;
              r_state <= S_SUB;
            end else begin
              r_i <= r_i + IW'(1);
            end
          end else begin
            r_j <= r_j + IW'(1);
          end
        end
        S_SUB: begin
          r_t     <= r_x - r_acc;
          r_state <= S_COR1;
        end
        S_COR1: begin
          r_t     <= w_t_cor;
          r_state <= S_COR2;
        end
        S_COR2: begin
          // Outputs are registered here so they appear together with DONE.
          r_t         <= w_t_cor;
          r_r         <= w_t_cor[RADIX-1:0];
          r_corr      <= (w_t_cor >= w_m_ext);
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.r         = r_r;
  assign bus.corr_err  = r_corr;

endmodule
`default_nettype wire

// File: tb/tb_barrett_reduce_tail.sv
`default_nettype none
// ============================================================================
// Module      : tb_barrett_reduce_tail
// Description : Vector table, directed corner sequences and random jobs checked
//               against a plain-arithmetic Barrett tail model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_barrett_reduce_tail;
  localparam int RADIX = 54;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  barrett_reduce_tail_if #(.RADIX(RADIX)) bus ();

  barrett_reduce_tail #(.RADIX(RADIX), .LIMB(18)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [53:0] q;
    logic [55:0] x;
    logic [53:0] m;
    logic [53:0] r;
    logic        corr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: full-width arithmetic, no limbs.
  function automatic logic [54:0] model(input logic [53:0] q, input logic [55:0] x,
                                        input logic [53:0] m);
    logic [107:0] p;
    logic [55:0]  t;
    logic [55:0]  mm;
    p  = q * m;
    t  = x - p[55:0];
    mm = {2'b00, m};
    for (int k = 0; k < 2; k++) if (t >= mm) t = t - mm;
    return {(t >= mm), t[53:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One job: accept, latency, hold under backpressure, result, handshake.
  task automatic run_job(input string name, input logic [53:0] q, input logic [55:0] x,
                         input logic [53:0] m, input logic [53:0] exp_r,
                         input logic exp_corr, input int hold, input bit busy_noise);
    int          w;
    int          lat;
    logic [53:0] r0;
    logic        c0;
    bit          stable;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      tick();
      w++;
    end
    if (!bus.in_ready) begin
      check({name, " in_ready timeout"}, 64'(bus.in_ready), 64'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.q = q;
    bus.x_low = x;
    bus.m = m;
    tick();
    bus.in_valid = busy_noise;
    bus.q = {$urandom, $urandom};
    bus.x_low = {$urandom, $urandom};
    bus.m = {$urandom, $urandom};
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    bus.in_valid = 1'b0;
    check({name, " latency"}, 64'(lat), 64'd12);
    if (!bus.out_valid) return;
    r0 = bus.r;
    c0 = bus.corr_err;
    stable = 1'b1;
    bus.out_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      tick();
      if (!bus.out_valid || bus.in_ready || bus.r !== r0 || bus.corr_err !== c0) stable = 1'b0;
    end
    if (hold > 0) check({name, " hold stable"}, 64'(stable), 64'd1);
    check({name, " r"}, 64'(r0), 64'(exp_r));
    check({name, " corr_err"}, 64'(c0), 64'(exp_corr));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({name, " post-handshake out_valid,in_ready"},
          64'({bus.out_valid, bus.in_ready}), 64'b01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [54:0]  e;
    logic [53:0]  rq;
    logic [53:0]  rm;
    logic [55:0]  rx;
    logic [107:0] rp;

    n_tests = 0;
    n_fail  = 0;
    vecs[0] = '{q: 54'd3, x: 56'd300, m: 54'd97, r: 54'd9,   corr: 1'b0};
    vecs[1] = '{q: 54'd1, x: 56'd300, m: 54'd97, r: 54'd9,   corr: 1'b0};
    vecs[2] = '{q: 54'd0, x: 56'd300, m: 54'd97, r: 54'd106, corr: 1'b1};
    vecs[3] = '{q: 54'd1, x: 56'd5,   m: 54'd97, r: 54'h3F_FFFF_FFFF_FEE2, corr: 1'b1};
    vecs[4] = '{q: 54'd5, x: 56'd123, m: 54'd0,  r: 54'd123, corr: 1'b1};
    vecs[5] = '{q: 54'd0, x: 56'd1000, m: 54'd2000, r: 54'd1000, corr: 1'b0};

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.q = '0;
    bus.x_low = '0;
    bus.m = '0;
    #23;
    check("reset out_valid,in_ready,corr_err", 64'({bus.out_valid, bus.in_ready, bus.corr_err}), 64'b010);
    check("reset r", 64'(bus.r), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 6; v++)
      run_job($sformatf("vec%0d", v), vecs[v].q, vecs[v].x, vecs[v].m,
              vecs[v].r, vecs[v].corr, v % 3, v[0]);

    // Full width with 5 cycles of backpressure.
    rq = 54'h3F_FFFF_FFFF_FFFF;
    rm = 54'h3F_FFFF_FFFF_FFDF;
    e  = model(rq, 56'h0, rm);
    run_job("fullwidth", rq, 56'h0, rm, e[53:0], e[54], 5, 1'b1);

    // Reset during the 4th MUL edge, then a clean job.
    bus.in_valid = 1'b1;
    bus.q = 54'h3F_FFFF_FFFF_FFFF;
    bus.x_low = 56'hAB_CDEF_0123_4567;
    bus.m = 54'h2A_AAAA_AAAA_AAAB;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    check("mid-MUL reset out_valid,in_ready", 64'({bus.out_valid, bus.in_ready}), 64'b01);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_job("after reset", 54'd3, 56'd300, 54'd97, 54'd9, 1'b0, 0, 1'b0);

    // Random jobs: half realistic estimates near x/m, half arbitrary.
    for (int n = 0; n < 30; n++) begin
      rq = {$urandom, $urandom};
      rm = {$urandom, $urandom};
      rx = {$urandom, $urandom};
      if (n[0]) begin
        rm = rm | 54'd1;
        rp = rq * rm;
        rx = rp[55:0] + 56'($urandom_range(0, 2)) * {2'b00, rm} + 56'(rx[53:0] % rm);
      end
      e = model(rq, rx, rm);
      run_job($sformatf("rand%0d", n), rq, rx, rm, e[53:0], e[54], n % 4, n[1]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
